// File: rtl/mkio_rx_writer.sv
// mkio_rx_writer: MKIO (MIL-STD-1553) remote-terminal receive-message assembler.
// It watches the stream of decoded words from the Manchester decoder. When it sees
// a receive command addressed to this terminal (RT_ADDR) or to broadcast (31), it
// writes the data words that follow into the 32x16 data RAM through the RAM's
// write port, and then reports either completion or an abort.
//
// Ports:
//   clk, rst_n                       clock (also the RAM wrclock), async active-low reset
//   word_valid, word_data            one-cycle decoded-word strobe and its 16-bit payload
//   word_is_cmd, word_perr           command-sync flag and parity/Manchester error flag
//   wr_data, wr_addr, wr_en          RAM write port (data, wraddress, wren)
//   busy                             a message is being received
//   msg_done, msg_err                one-cycle completion / abort pulses
//   msg_sa, msg_wc, msg_bcast        subaddress, word count (1..32) and broadcast flag
//                                    of the current or most recent message
module mkio_rx_writer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned RT_ADDR    = 3,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  word_valid,
    input  logic [DATA_WIDTH-1:0] word_data,
    input  logic                  word_is_cmd,
    input  logic                  word_perr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  msg_done,
    output logic                  msg_err,
    output logic [4:0]            msg_sa,
    output logic [5:0]            msg_wc,
    output logic                  msg_bcast
);

    localparam int unsigned IDX_W    = 6;
    localparam int unsigned GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [4:0]  BCAST_RT = 5'd31;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [4:0]            sa_q, sa_d;
    logic [5:0]            wc_q, wc_d;
    logic                  bcast_q, bcast_d;

    // Command word fields.
    logic [4:0]       cmd_rt_c;
    logic             cmd_tr_c;
    logic [4:0]       cmd_sa_c;
    logic [4:0]       cmd_wc_c;
    logic             cmd_ok_c;
    logic             accept_c;
    logic [IDX_W-1:0] idx_inc_c;

    assign cmd_rt_c  = word_data[15:11];
    assign cmd_tr_c  = word_data[10];
    assign cmd_sa_c  = word_data[9:5];
    assign cmd_wc_c  = word_data[4:0];
    assign idx_inc_c = idx_q + IDX_W'(1);

    // A receive command for us or broadcast; subaddresses 0 and 31 are mode codes.
    assign cmd_ok_c = word_valid && word_is_cmd && !word_perr
                      && (cmd_rt_c == 5'(RT_ADDR) || cmd_rt_c == BCAST_RT)
                      && !cmd_tr_c
                      && cmd_sa_c != 5'd0 && cmd_sa_c != 5'd31;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sa_d      = sa_q;
        wc_d      = wc_q;
        bcast_d   = bcast_q;
        accept_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept_c = cmd_ok_c;
            end
            RECV: begin
                gap_d = gap_q + GAP_W'(1);
                if (word_valid && word_is_cmd) begin
                    // Any command aborts; it may also immediately start a new message.
                    err_d    = 1'b1;
                    state_d  = IDLE;
                    accept_c = cmd_ok_c;
                end else if (word_valid && word_perr) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (word_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q[ADDR_WIDTH-1:0];
                    wr_data_d = word_data;
                    idx_d     = idx_inc_c;
                    gap_d     = '0;
                    if (idx_inc_c == wc_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    // Silence limit reached; a word in this cycle would have won instead.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept_c) begin
            state_d = RECV;
            idx_d   = '0;
            gap_d   = '0;
            sa_d    = cmd_sa_c;
            wc_d    = (cmd_wc_c == 5'd0) ? 6'd32 : {1'b0, cmd_wc_c};
            bcast_d = (cmd_rt_c == BCAST_RT);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sa_q      <= '0;
            wc_q      <= '0;
            bcast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= (state_d == RECV);
            done_q    <= done_d;
            err_q     <= err_d;
            sa_q      <= sa_d;
            wc_q      <= wc_d;
            bcast_q   <= bcast_d;
        end
    end

    assign wr_data   = wr_data_q;
    assign wr_addr   = wr_addr_q;
    assign wr_en     = wr_en_q;
    assign busy      = busy_q;
    assign msg_done  = done_q;
    assign msg_err   = err_q;
    assign msg_sa    = sa_q;
    assign msg_wc    = wc_q;
    assign msg_bcast = bcast_q;

endmodule

// File: tb/tb_mkio_rx_writer.sv
// Scoreboard bench for mkio_rx_writer: stimulus tasks update a message-level model
// and queue expected output events; a monitor compares the DUT's events against them.
module tb_mkio_rx_writer;

    localparam int unsigned GAP = 40;

    logic        clk;
    logic        rst_n;
    logic        word_valid;
    logic [15:0] word_data;
    logic        word_is_cmd;
    logic        word_perr;
    logic [15:0] wr_data;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic        busy;
    logic        msg_done;
    logic        msg_err;
    logic [4:0]  msg_sa;
    logic [5:0]  msg_wc;
    logic        msg_bcast;

    mkio_rx_writer #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(5),
        .RT_ADDR   (3),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_is_cmd(word_is_cmd),
        .word_perr  (word_perr),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .busy       (busy),
        .msg_done   (msg_done),
        .msg_err    (msg_err),
        .msg_sa     (msg_sa),
        .msg_wc     (msg_wc),
        .msg_bcast  (msg_bcast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One observable output event: a write (possibly the final one) or an abort.
    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] data;
        logic        done;
        logic        err;
        logic        busy;
        logic [4:0]  sa;
        logic [5:0]  wc;
        logic        bcast;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Message-level model.
    bit  m_in     = 0;
    int  m_n      = 0;
    int  m_wc     = 0;
    int  m_silent = 0;
    int  m_sa     = 0;
    bit  m_bc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_rx_cmd(input logic [15:0] d);
        int rt, sa;
        rt = int'(d[15:11]);
        sa = int'(d[9:5]);
        return (rt == 3 || rt == 31) && !d[10] && sa != 0 && sa != 31;
    endfunction

    // Drive one clock cycle of input and predict its effect on the outputs.
    task automatic step(input bit v, input logic [15:0] d, input bit c, input bit p);
        ev_t e;
        bit  have;
        e    = '0;
        have = 0;
        if (m_in && !v) begin
            m_silent++;
            if (m_silent == GAP) begin
                e.err = 1; have = 1; m_in = 0;
            end
        end else if (v && c) begin
            if (m_in) begin
                e.err = 1; have = 1; m_in = 0;
            end
            if (!p && is_rx_cmd(d)) begin
                m_in = 1; m_n = 0; m_silent = 0;
                m_sa = int'(d[9:5]);
                m_wc = (d[4:0] == 5'd0) ? 32 : int'(d[4:0]);
                m_bc = (d[15:11] == 5'd31);
            end
        end else if (v && m_in) begin
            if (p) begin
                e.err = 1; have = 1; m_in = 0;
            end else begin
                e.wr = 1; e.addr = 5'(m_n); e.data = d; have = 1;
                m_n++;
                m_silent = 0;
                if (m_n == m_wc) begin
                    e.done = 1; e.sa = 5'(m_sa); e.wc = 6'(m_wc); e.bcast = m_bc;
                    m_in = 0;
                end
            end
        end
        if (have) begin
            e.busy = m_in;
            exp_q.push_back(e);
        end
        word_valid  = v;
        word_data   = d;
        word_is_cmd = c;
        word_perr   = p;
        @(posedge clk);
        #1;
        word_valid  = 0;
        word_is_cmd = 0;
        word_perr   = 0;
    endtask

    task automatic cmd(input logic [15:0] d);
        step(1, d, 1, 0);
    endtask

    task automatic dat(input logic [15:0] d, input bit p);
        step(1, d, 0, p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0);
    endtask

    // Monitor: every write/done/err cycle must match the next expected event.
    always @(negedge clk) begin
        if (rst_n && (wr_en || msg_done || msg_err)) begin
            ev_t a;
            ev_t x;
            a       = '0;
            a.wr    = wr_en;
            a.addr  = wr_en ? wr_addr : 5'd0;
            a.data  = wr_en ? wr_data : 16'd0;
            a.done  = msg_done;
            a.err   = msg_err;
            a.busy  = busy;
            a.sa    = msg_done ? msg_sa : 5'd0;
            a.wc    = msg_done ? msg_wc : 6'd0;
            a.bcast = msg_done ? msg_bcast : 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got 0x%0h, expected no event", a);
            end else begin
                x = exp_q.pop_front();
                if (a !== x) begin
                    n_fail++;
                    $display("FAIL event: got 0x%0h, expected 0x%0h", a, x);
                end
            end
        end
    end

    task automatic check_all_reset(input string name);
        check(name, {wr_data, 3'b0, wr_addr, wr_en, busy, msg_done, msg_err}, 32'h0);
        check({name, "_msg"}, {19'b0, msg_sa, msg_wc, msg_bcast}, 32'h0);
    endtask

    initial begin
        int nw, rt, sa, wc;
        logic [15:0] cw;
        rst_n       = 0;
        word_valid  = 0;
        word_data   = 0;
        word_is_cmd = 0;
        word_perr   = 0;
        #23;
        check_all_reset("reset_values");
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(2);

        // Basic 5-word message to RT 3, SA 3.
        cmd(16'h1865);
        for (int i = 0; i < 5; i++) dat(16'hA000 + 16'(i), 0);
        idle(3);
        check("t1_sa", 32'(msg_sa), 32'd3);
        check("t1_wc", 32'(msg_wc), 32'd5);
        check("t1_busy", 32'(busy), 32'd0);

        // Broadcast, word count 0 meaning 32, back-to-back.
        cmd(16'hF860);
        for (int i = 0; i < 32; i++) dat(16'hB000 + 16'(i), 0);
        idle(3);
        check("t2_bcast", 32'(msg_bcast), 32'd1);
        check("t2_wc", 32'(msg_wc), 32'd32);

        // Gap timeout after one of two words, then a stray data word.
        cmd(16'h1862);
        dat(16'hC000, 0);
        idle(GAP + 3);
        check("t3_busy", 32'(busy), 32'd0);
        dat(16'hC001, 0);
        idle(3);

        // Gap boundary: a word arriving in the last allowed cycle is accepted.
        cmd(16'h1863);
        dat(16'hD000, 0);
        idle(GAP - 1);
        dat(16'hD001, 0);
        idle(GAP - 1);
        dat(16'hD002, 0);
        idle(3);

        // Parity error on the third data word.
        cmd(16'h1864);
        dat(16'hE000, 0);
        dat(16'hE001, 0);
        dat(16'hE002, 1);
        dat(16'hE003, 0);
        idle(3);

        // New command mid-message aborts and restarts.
        cmd(16'h1864);
        dat(16'hF000, 0);
        dat(16'hF001, 0);
        cmd(16'h1841);
        dat(16'hF002, 0);
        idle(3);
        check("t5_sa", 32'(msg_sa), 32'd2);
        check("t5_wc", 32'(msg_wc), 32'd1);

        // Ignored: other RT, transmit, mode codes (SA 0 and 31), command with parity error.
        cmd(16'h2865);
        dat(16'h1111, 0);
        cmd(16'h1C65);
        dat(16'h2222, 0);
        cmd(16'h1805);
        cmd(16'h1BE5);
        step(1, 16'h1865, 1, 1);
        dat(16'h3333, 0);
        idle(3);
        check("t6_busy", 32'(busy), 32'd0);

        // Reset mid-message.
        cmd(16'h1865);
        dat(16'h4000, 0);
        dat(16'h4001, 0);
        idle(2);
        check("t7_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 0;
        m_in  = 0;
        #1;
        check_all_reset("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        check_all_reset("after_reset");
        dat(16'h4002, 0);
        idle(3);

        // Randomised traffic.
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 2))
                0: rt = 3;
                1: rt = 31;
                default: rt = 5;
            endcase
            sa = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 31));
            wc = int'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) wc = $urandom_range(1, 4);
            cw = {5'(rt), ($urandom_range(0, 7) == 0), 5'(sa), 5'(wc)};
            step(1, cw, 1, ($urandom_range(0, 19) == 0));
            nw = int'($urandom_range(0, 34));
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 14) == 0)
                    idle(int'($urandom_range(GAP - 2, GAP + 1)));
                else if ($urandom_range(0, 2) == 0)
                    idle(int'($urandom_range(1, 3)));
                dat(16'($urandom), ($urandom_range(0, 39) == 0));
            end
        end
        idle(GAP + 5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mkio_rx_writer.md
# mkio_rx_writer

Receive-side message assembler for the MKIO (MIL-STD-1553) remote terminal path. Consumes decoded 16-bit words from the Manchester decoder, recognises receive commands addressed to this terminal or broadcast, and writes the following data words into the device data memory (32 × 16 dual-port RAM) through its write port. Reports per-message completion or error to the terminal controller.

## Interface

Parameters:
- `DATA_WIDTH`, 16, word width; fixed at 16 by 1553 framing.
- `ADDR_WIDTH`, 5, memory address width; covers 32 data words.
- `RT_ADDR`, 3, this terminal's 5-bit address.
- `GAP_CYCLES`, 1000, maximum clk cycles allowed between consecutive words of one message.

Ports:
- `clk`  in  1  system clock; also drives the memory `wrclock`.
- `rst_n`  in  1  asynchronous active-low reset.
- `word_valid`  in  1  one-cycle strobe: decoded word present.
- `word_data`  in  16  decoded word, bit 15 = first bit on bus.
- `word_is_cmd`  in  1  word carried command/status sync (qualified by `word_valid`).
- `word_perr`  in  1  parity/Manchester error on this word (qualified by `word_valid`).
- `wr_data`  out  16  to memory `data`.
- `wr_addr`  out  5  to memory `wraddress`.
- `wr_en`  out  1  to memory `wren`.
- `busy`  out  1  high while a message is being received.
- `msg_done`  out  1  one-cycle pulse: message complete, all words written.
- `msg_err`  out  1  one-cycle pulse: message aborted.
- `msg_sa`  out  5  subaddress of current/last message.
- `msg_wc`  out  6  expected word count of current/last message, 1..32.
- `msg_bcast`  out  1  current/last message was broadcast (RT address 31).

## Operation

- Command word fields: [15:11] RT address, [10] T/R, [9:5] subaddress, [4:0] word count (0 means 32).
- States: IDLE, RECV.
- IDLE: on `word_valid & word_is_cmd & ~word_perr` with RT field = `RT_ADDR` or 31, T/R = 0, subaddress not 0 and not 31, go to RECV. Latch `msg_sa`, `msg_wc`, `msg_bcast`; clear the word index and the gap counter. All other words, including data words, transmit commands, mode codes, and commands with parity errors, are ignored.
- RECV: on data word (`word_valid & ~word_is_cmd & ~word_perr`):
  - write it at `wr_addr` = index, then increment index.
  - When index reaches `msg_wc`, pulse `msg_done` and return to IDLE.
- RECV abort conditions, each pulsing `msg_err` and returning to IDLE:
  - data word with `word_perr`.
  - gap counter reaching `GAP_CYCLES` with no word.
  - any command-sync word.
- Command word in RECV: after the abort, the same word is evaluated as an IDLE command. A valid receive command re-enters RECV in the same cycle, with the index restarted at 0.
- Words already written before an abort remain in memory. No rollback.
- Gap counter: counts clk cycles in RECV, cleared on every accepted word. If `word_valid` coincides with the terminal count, the word wins.
- Index arithmetic is 6-bit. `wr_addr` = index[4:0]. The index never exceeds 32.

## Timing

- All outputs are registered. Reset values: `wr_data` = 0, `wr_addr` = 0, `wr_en` = 0, `busy` = 0, `msg_done` = 0, `msg_err` = 0, `msg_sa` = 0, `msg_wc` = 0, `msg_bcast` = 0. State = IDLE.
- Write latency: `wr_en`, `wr_addr` and `wr_data` are asserted for exactly one cycle, one cycle after the accepting `word_valid`.
- `msg_done` is asserted in the same cycle as the final `wr_en`.
- `msg_err` is asserted one cycle after the aborting event.
- `busy` rises one cycle after the command is accepted. It falls in the cycle `msg_done`/`msg_err` is high, unless a new command re-entered RECV.
- Back-to-back `word_valid` on consecutive cycles must be accepted without loss.
- `rst_n` asserted mid-message: immediate return to IDLE, no pulse, `wr_en` low.

## Test plan

- Command 0x1865 (RT 3, R, SA 3, WC 5), then data 0xA000..0xA004 → five writes to addresses 0..4; `msg_done` coincides with the write to address 4; `msg_sa` = 3, `msg_wc` = 5.
- Command 0xF860 (broadcast, SA 3, WC 0 = 32), then 32 back-to-back data words → addresses 0..31 written, `msg_bcast` = 1, `msg_wc` = 32, one `msg_done`.
- Command 0x1862 (WC 2), one data word, then silence for `GAP_CYCLES` → one write, `msg_err` pulse, `busy` low; a later stray data word produces no write.
- Command WC 4; the third data word has `word_perr` → two writes, `msg_err`, no third write.
- Command WC 4, two data words, then new command 0x1841 (SA 2, WC 1) and one data word → `msg_err`, then a write to address 0, `msg_done`, `msg_sa` = 2.
- Ignored inputs: command for RT 5, transmit command 0x1C65, mode code SA 0, and a valid command with `word_perr` → no `wr_en` and no pulses; `rst_n` low mid-message → IDLE, all outputs at reset values.
